// File: rtl/dvfs_pkg.sv
// Shared types for the DVFS level sequencer: FSM state encoding, load decision
// encoding and the level-index width derivation.
package dvfs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VOLT_UP,
        ST_FREQ_UP,
        ST_FREQ_DOWN,
        ST_VOLT_DOWN
    } dvfs_state_e;

    typedef enum logic [1:0] {
        DEC_NONE,
        DEC_UP,
        DEC_DOWN
    } dvfs_dec_e;

    // Width of a level index; at least one bit even for a two-level table.
    function automatic int lvl_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dvfs_load_eval.sv
// Load evaluator: compares cpu_usage against the thresholds around the current
// level and emits a one-cycle step strobe once a decision has persisted long enough.
module dvfs_load_eval
    import dvfs_pkg::*;
#(
    parameter int NUM_LEVELS   = 4,
    parameter int USAGE_W      = 8,
    parameter int HYST         = 5,
    parameter int DWELL_CYCLES = 4,
    parameter int LVL_W        = lvl_width(NUM_LEVELS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              idle,
    input  logic                              en,
    input  logic [LVL_W-1:0]                  level,
    input  logic [USAGE_W-1:0]                cpu_usage,
    input  logic [(NUM_LEVELS-1)*USAGE_W-1:0] up_thr,
    output logic                              step_up,
    output logic                              step_down
);

    localparam int TOP      = NUM_LEVELS - 1;
    localparam int CNT_W    = $clog2(DWELL_CYCLES + 1);
    localparam int HYST_SAT = (HYST < (1 << USAGE_W)) ? HYST : (1 << USAGE_W) - 1;
    localparam logic [USAGE_W-1:0] HYST_V  = HYST_SAT[USAGE_W-1:0];
    localparam logic [CNT_W-1:0]   DWELL_V = CNT_W'(DWELL_CYCLES);

    // Top entry is padding so any level indexes the table safely.
    logic [USAGE_W-1:0] thr_arr [NUM_LEVELS];

    generate
        for (genvar gi = 0; gi < NUM_LEVELS; gi++) begin : g_thr
            if (gi < TOP) begin : g_real
                assign thr_arr[gi] = up_thr[gi*USAGE_W +: USAGE_W];
            end else begin : g_pad
                assign thr_arr[gi] = '1;
            end
        end
    endgenerate

    logic [USAGE_W-1:0] thr_hi;
    logic [USAGE_W-1:0] thr_lo;
    logic [USAGE_W-1:0] dn_thr;
    logic [LVL_W-1:0]   level_m1;
    dvfs_dec_e          dec;

    always_comb begin
        level_m1 = level - LVL_W'(1);
        thr_hi   = thr_arr[level];
        thr_lo   = (level != '0) ? thr_arr[level_m1] : '0;
        dn_thr   = (thr_lo > HYST_V) ? (thr_lo - HYST_V) : '0;
        dec      = DEC_NONE;
        if ((int'(level) < TOP) && (cpu_usage >= thr_hi)) begin
            dec = DEC_UP;
        end else if ((level != '0) && (cpu_usage < dn_thr)) begin
            dec = DEC_DOWN;
        end
    end

    logic [CNT_W-1:0] cnt_q, cnt_d, run_len;
    dvfs_dec_e        dec_q, dec_d;
    logic             fire;

    // run_len counts the current cycle; the counter never exceeds DWELL-1 at rest.
    always_comb begin
        run_len = '0;
        if (dec != DEC_NONE) begin
            run_len = (dec == dec_q) ? (cnt_q + CNT_W'(1)) : CNT_W'(1);
        end
        fire  = idle && en && (dec != DEC_NONE) && (run_len == DWELL_V);
        cnt_d = run_len;
        dec_d = dec;
        if (!idle || !en || fire) begin
            cnt_d = '0;
            dec_d = DEC_NONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            dec_q <= DEC_NONE;
        end else begin
            cnt_q <= cnt_d;
            dec_q <= dec_d;
        end
    end

    assign step_up   = fire && (dec == DEC_UP);
    assign step_down = fire && (dec == DEC_DOWN);

endmodule

// File: rtl/dvfs_level_sequencer.sv
// DVFS level sequencer: steps one operating point at a time, raising voltage
// before frequency on the way up and lowering frequency before voltage on the way down.
module dvfs_level_sequencer
    import dvfs_pkg::*;
#(
    parameter int NUM_LEVELS      = 4,
    parameter int USAGE_W         = 8,
    parameter int HYST            = 5,
    parameter int DWELL_CYCLES    = 4,
    parameter int PLL_LOCK_CYCLES = 8,
    localparam int LVL_W          = lvl_width(NUM_LEVELS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              en,
    input  logic [USAGE_W-1:0]                cpu_usage,
    input  logic [(NUM_LEVELS-1)*USAGE_W-1:0] up_thr,
    input  logic                              volt_ack,
    output logic                              volt_req,
    output logic [LVL_W-1:0]                  volt_sel,
    output logic [LVL_W-1:0]                  freq_sel,
    output logic [LVL_W-1:0]                  cur_level,
    output logic                              busy
);

    localparam int LOCK_W = (PLL_LOCK_CYCLES > 1) ? $clog2(PLL_LOCK_CYCLES) : 1;
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(PLL_LOCK_CYCLES - 1);

    dvfs_state_e       state_q, state_d;
    logic [LVL_W-1:0]  cur_level_q, cur_level_d;
    logic [LVL_W-1:0]  volt_sel_q, volt_sel_d;
    logic [LVL_W-1:0]  freq_sel_q, freq_sel_d;
    logic              volt_req_q, volt_req_d;
    logic              busy_q, busy_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              step_up, step_down;

    dvfs_load_eval #(
        .NUM_LEVELS   (NUM_LEVELS),
        .USAGE_W      (USAGE_W),
        .HYST         (HYST),
        .DWELL_CYCLES (DWELL_CYCLES),
        .LVL_W        (LVL_W)
    ) u_load_eval (
        .clk       (clk),
        .reset     (reset),
        .idle      (state_q == ST_IDLE),
        .en        (en),
        .level     (cur_level_q),
        .cpu_usage (cpu_usage),
        .up_thr    (up_thr),
        .step_up   (step_up),
        .step_down (step_down)
    );

    logic lock_done;
    assign lock_done = (lock_cnt_q == LOCK_LAST);

    always_comb begin
        state_d     = state_q;
        cur_level_d = cur_level_q;
        volt_sel_d  = volt_sel_q;
        freq_sel_d  = freq_sel_q;
        volt_req_d  = volt_req_q;
        lock_cnt_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (step_up) begin
                    state_d    = ST_VOLT_UP;
                    volt_sel_d = cur_level_q + LVL_W'(1);
                    volt_req_d = 1'b1;
                end else if (step_down) begin
                    state_d    = ST_FREQ_DOWN;
                    freq_sel_d = cur_level_q - LVL_W'(1);
                end
            end
            ST_VOLT_UP: begin
                if (volt_ack) begin
                    state_d    = ST_FREQ_UP;
                    volt_req_d = 1'b0;
                    freq_sel_d = volt_sel_q;
                end
            end
            ST_FREQ_UP: begin
                if (lock_done) begin
                    state_d     = ST_IDLE;
                    cur_level_d = freq_sel_q;
                end else begin
                    lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                end
            end
            ST_FREQ_DOWN: begin
                // Voltage only drops once the PLL has settled at the lower frequency.
                if (lock_done) begin
                    state_d    = ST_VOLT_DOWN;
                    volt_sel_d = freq_sel_q;
                    volt_req_d = 1'b1;
                end else begin
                    lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                end
            end
            ST_VOLT_DOWN: begin
                if (volt_ack) begin
                    state_d     = ST_IDLE;
                    volt_req_d  = 1'b0;
                    cur_level_d = volt_sel_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cur_level_q <= '0;
            volt_sel_q  <= '0;
            freq_sel_q  <= '0;
            volt_req_q  <= 1'b0;
            busy_q      <= 1'b0;
            lock_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cur_level_q <= cur_level_d;
            volt_sel_q  <= volt_sel_d;
            freq_sel_q  <= freq_sel_d;
            volt_req_q  <= volt_req_d;
            busy_q      <= busy_d;
            lock_cnt_q  <= lock_cnt_d;
        end
    end

    assign volt_req  = volt_req_q;
    assign volt_sel  = volt_sel_q;
    assign freq_sel  = freq_sel_q;
    assign cur_level = cur_level_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dvfs_level_sequencer.sv
// Bench for dvfs_level_sequencer: directed scenarios followed by random load,
// enable, ack and reset activity, all compared every cycle against a behavioural model.
module tb_dvfs_level_sequencer;

    localparam int NL = 4;
    localparam int HY = 5;
    localparam int DW = 4;
    localparam int LK = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [7:0]  cpu_usage;
    logic [23:0] up_thr;
    logic        volt_ack;
    logic        volt_req;
    logic [1:0]  volt_sel;
    logic [1:0]  freq_sel;
    logic [1:0]  cur_level;
    logic        busy;

    always #5 clk = ~clk;

    dvfs_level_sequencer #(
        .NUM_LEVELS      (NL),
        .USAGE_W         (8),
        .HYST            (HY),
        .DWELL_CYCLES    (DW),
        .PLL_LOCK_CYCLES (LK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .cpu_usage (cpu_usage),
        .up_thr    (up_thr),
        .volt_ack  (volt_ack),
        .volt_req  (volt_req),
        .volt_sel  (volt_sel),
        .freq_sel  (freq_sel),
        .cur_level (cur_level),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: level, commanded selects, and a phase number for
    // "waiting on regulator" / "waiting on PLL", plus a history of recent decisions.
    int thr [3] = '{30, 60, 85};
    int m_level, m_volt, m_freq, m_req, m_phase, m_lock;
    int hist [$];

    function automatic int decide(input int lvl, input int u);
        int lo;
        if (lvl < NL - 1 && u >= thr[lvl]) return 1;
        if (lvl > 0) begin
            lo = thr[lvl-1] - HY;
            if (lo < 0) lo = 0;
            if (u < lo) return 2;
        end
        return 0;
    endfunction

    task automatic model_clear();
        m_level = 0; m_volt = 0; m_freq = 0; m_req = 0; m_phase = 0; m_lock = 0;
        hist.delete();
    endtask

    task automatic model_step();
        int d;
        case (m_phase)
            0: begin
                if (!en) hist.delete();
                else begin
                    d = decide(m_level, int'(cpu_usage));
                    if (d == 0) hist.delete();
                    else begin
                        if (hist.size() > 0 && hist[0] != d) hist.delete();
                        hist.push_back(d);
                        if (hist.size() == DW) begin
                            hist.delete();
                            if (d == 1) begin
                                m_volt = m_level + 1; m_req = 1; m_phase = 1;
                            end else begin
                                m_freq = m_level - 1; m_lock = LK; m_phase = 3;
                            end
                        end
                    end
                end
            end
            1: if (volt_ack) begin m_req = 0; m_freq = m_level + 1; m_lock = LK; m_phase = 2; end
            2: begin m_lock--; if (m_lock == 0) begin m_level = m_freq; m_phase = 0; end end
            3: begin m_lock--; if (m_lock == 0) begin m_volt = m_level - 1; m_req = 1; m_phase = 4; end end
            4: if (volt_ack) begin m_req = 0; m_level = m_volt; m_phase = 0; end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        check("volt_sel", volt_sel, m_volt);
        check("freq_sel", freq_sel, m_freq);
        check("cur_level", cur_level, m_level);
        check("volt_req", volt_req, m_req);
        check("busy", busy, (m_phase != 0) ? 1 : 0);
        check("volt_ge_freq", (volt_sel >= freq_sel) ? 1 : 0, 1);
    endtask

    task automatic cycle(input int u, input logic e, input logic a);
        cpu_usage = u[7:0];
        en        = e;
        volt_ack  = a;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    // Asynchronous reset pulse taken between clock edges.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        check("rst_volt_sel", volt_sel, 0);
        check("rst_freq_sel", freq_sel, 0);
        check("rst_cur_level", cur_level, 0);
        check("rst_volt_req", volt_req, 0);
        check("rst_busy", busy, 0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int u, t;
        reset     = 1'b1;
        en        = 1'b1;
        cpu_usage = '0;
        volt_ack  = 1'b0;
        up_thr    = {8'd85, 8'd60, 8'd30};
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Step up 0 -> 1 with a slow regulator.
        repeat (4) cycle(50, 1'b1, 1'b0);
        check("up_volt_sel", volt_sel, 1);
        check("up_freq_hold", freq_sel, 0);
        repeat (2) cycle(50, 1'b1, 1'b0);
        cycle(50, 1'b1, 1'b1);
        check("up_freq_sel", freq_sel, 1);
        repeat (7) cycle(50, 1'b1, 1'b0);
        check("up_locking", busy, 1);
        cycle(50, 1'b1, 1'b0);
        check("up_done_busy", busy, 0);
        check("up_done_level", cur_level, 1);

        // Inside the hysteresis band, then below it.
        repeat (10) cycle(27, 1'b1, 1'b0);
        check("hyst_hold", cur_level, 1);
        repeat (4) cycle(24, 1'b1, 1'b0);
        check("dn_freq_first", freq_sel, 0);
        check("dn_volt_hold", volt_sel, 1);
        repeat (8) cycle(24, 1'b1, 1'b0);
        check("dn_volt_req", volt_req, 1);
        check("dn_volt_sel", volt_sel, 0);
        cycle(24, 1'b1, 1'b1);
        check("dn_done_level", cur_level, 0);
        repeat (6) cycle(24, 1'b1, 1'b1);

        // Back to level 1, then a too-short burst must not step up.
        repeat (4) cycle(50, 1'b1, 1'b0);
        cycle(50, 1'b1, 1'b1);
        repeat (9) cycle(50, 1'b1, 1'b0);
        repeat (3) cycle(90, 1'b1, 1'b0);
        repeat (6) cycle(50, 1'b1, 1'b0);
        check("burst_level", cur_level, 1);
        check("burst_req", volt_req, 0);

        // Reset while waiting for the regulator.
        repeat (4) cycle(90, 1'b1, 1'b0);
        repeat (6) cycle(90, 1'b1, 1'b0);
        check("stall_req", volt_req, 1);
        check("stall_freq", freq_sel, 1);
        #2;
        do_reset();

        // Climb to the top with an always-acking regulator, then hold there.
        repeat (50) cycle(100, 1'b1, 1'b1);
        check("top_level", cur_level, 3);
        check("top_no_req", volt_req, 0);
        repeat (20) cycle(0, 1'b0, 1'b0);
        check("en_off_level", cur_level, 3);
        check("en_off_busy", busy, 0);
        repeat (3) cycle(0, 1'b1, 1'b0);
        check("en_on_wait", busy, 0);
        cycle(0, 1'b1, 1'b0);
        check("en_on_start", busy, 1);
        check("en_on_freq", freq_sel, 2);

        // Random load, enable, ack and occasional reset.
        u = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 3) == 0) u = $urandom_range(0, 255);
                else begin
                    t = thr[$urandom_range(0, 2)];
                    u = t + int'($urandom_range(0, 12)) - 8;
                    if (u < 0) u = 0;
                end
            end
            cycle(u, ($urandom_range(0, 15) != 0), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 599) == 0) begin
                #2;
                do_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dvfs_level_sequencer.md
DVFS_LEVEL_SEQUENCER -- requirements
Module: dvfs_level_sequencer

Interface
REQ-001 Parameter NUM_LEVELS, 4, number of operating points (>=2); LVL_W = clog2(NUM_LEVELS).
REQ-002 Parameter USAGE_W, 8, width of the load input and of each threshold.
REQ-003 Parameter HYST, 5, down-threshold hysteresis in usage units.
REQ-004 Parameter DWELL_CYCLES, 4, consecutive cycles a decision must persist (>=1).
REQ-005 Parameter PLL_LOCK_CYCLES, 8, cycles waited after each freq_sel change (>=1).
REQ-006 Clock: clk, input, 1, all state changes on its rising edge.
REQ-007 Reset: reset, input, 1, asynchronous, active-high.
REQ-008 en  input  1  permits new level changes; an in-progress change always completes.
REQ-009 cpu_usage  input  USAGE_W  sampled load, unsigned.
REQ-010 up_thr  input  (NUM_LEVELS-1)*USAGE_W  slice i = threshold from level i to i+1; static, ascending (software-guaranteed).
REQ-011 volt_ack  input  1  regulator reports volt_sel reached.
REQ-012 volt_req  output  1  held high until volt_ack sampled high.
REQ-013 volt_sel / freq_sel  output  LVL_W each  commanded voltage / frequency level.
REQ-014 cur_level  output  LVL_W  last fully settled level; busy  output  1  high outside IDLE.

Function
REQ-015 Decision in IDLE at level L: UP if L<NUM_LEVELS-1 and cpu_usage >= up_thr[L]; DOWN if L>0 and cpu_usage < up_thr[L-1]-HYST (saturating at 0); else NONE.
REQ-016 Dwell counter increments while the decision is the same non-NONE value, and clears on NONE, on a decision change, or on leaving IDLE.
REQ-017 A transition starts on the cycle the same decision has held DWELL_CYCLES consecutive IDLE cycles with en=1; en=0 clears the dwell counter.
REQ-018 Exactly one level step per transition; a multi-level change requires repeated dwells.
REQ-019 States: IDLE, VOLT_UP, FREQ_UP, FREQ_DOWN, VOLT_DOWN.
REQ-020 Step up: VOLT_UP drives volt_sel=L+1 and volt_req=1 until volt_ack sampled high.
REQ-021 Step up, next cycle: FREQ_UP drives freq_sel=L+1 for PLL_LOCK_CYCLES cycles, then IDLE with cur_level=L+1.
REQ-022 Step down: FREQ_DOWN drives freq_sel=L-1 for PLL_LOCK_CYCLES cycles, then VOLT_DOWN.
REQ-023 VOLT_DOWN drives volt_sel=L-1 and volt_req=1 until volt_ack high, then IDLE with cur_level=L-1.
REQ-024 Invariant: volt_sel >= freq_sel in every cycle.
REQ-025 volt_ack low indefinitely: remain in the VOLT_* state and leave freq_sel unchanged; no timeout.
REQ-026 volt_ack high outside VOLT_* states: ignored.
REQ-027 cpu_usage changes during a transition do not abort or reverse it.
REQ-028 At level 0 DOWN never fires; at level NUM_LEVELS-1 UP never fires; volt_req stays low.

Reset
REQ-029 Reset asserted: state=IDLE; freq_sel, volt_sel, cur_level=0; volt_req, busy=0; dwell counter=0.
REQ-030 Reset mid-transition abandons the handshake immediately, with no completion cycle.

Structure
REQ-031 Package dvfs_pkg holds the state encoding and the LVL_W derivation.
REQ-032 Sub-module dvfs_load_eval holds the threshold compare, hysteresis and dwell counter, and outputs a one-cycle step_up/step_down strobe.

Verification (NUM_LEVELS=4, up_thr={30,60,85}, HYST=5, DWELL=4, LOCK=8)
REQ-033 Reset release, cpu_usage=50 held -> VOLT_UP after 4 cycles, volt_sel=1; ack 3 cycles later -> freq_sel=1; 8 cycles later busy=0, cur_level=1.
REQ-034 At level 1, cpu_usage=27 -> no change; cpu_usage=24 for 4 cycles -> freq_sel=0 first, volt_sel=0 8 cycles later plus ack.
REQ-035 At level 1, cpu_usage=90 for 3 cycles then 50 -> no transition, volt_req stays 0.
REQ-036 Reset pulse during VOLT_UP with ack low -> all outputs 0 asynchronously; invariant volt_sel >= freq_sel checked throughout.
REQ-037 At level 3, cpu_usage=100 -> no request; with en=0, cpu_usage=0 -> level held until en=1, then 4 cycles to start.
